// File: rtl/byte_serial_addsub_pkg.sv
// Shared constants for the byte-serial add/subtract unit: op codes and
// controller state encodings.
package byte_serial_addsub_pkg;

  // Operation select carried on the sub input
  localparam logic ADDSUB_OP_ADD = 1'b0;
  localparam logic ADDSUB_OP_SUB = 1'b1;

  // Controller state encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Width of the byte-step index for a given byte count
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/byte_serial_addsub_rca.sv
// byte_RCA: 8-bit ripple-carry adder used as the shared byte datapath.
module byte_RCA (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  // Ripple the carry through eight full-adder cells
  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    co = c;
  end

endmodule

// File: rtl/byte_serial_addsub.sv
// byte_serial_addsub: W-bit add/subtract built from one byte_RCA stepped
// over NBYTES cycles, least-significant byte first, with a start/busy/done
// handshake. Subtraction is A + ~B + 1 with the +1 seeded as the initial carry.
module byte_serial_addsub
  import byte_serial_addsub_pkg::*;
#(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] data_operandA,
  input  logic [W-1:0] data_operandB,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] data_result,
  output logic         carry_out,
  output logic         overflow
);

  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry_q;
  logic [W-1:0]     reg_a;
  logic [W-1:0]     reg_b;

  logic [7:0]       rca_a;
  logic [7:0]       rca_b;
  logic [7:0]       rca_s;
  logic             rca_co;

  // Select the current byte of each latched operand
  always_comb begin
    rca_a = reg_a[8*idx +: 8];
    rca_b = reg_b[8*idx +: 8];
  end

  byte_RCA u_rca (
    .a  (rca_a),
    .b  (rca_b),
    .ci (carry_q),
    .s  (rca_s),
    .co (rca_co)
  );

  // Controller, carry register and result register
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      carry_q     <= 1'b0;
      reg_a       <= '0;
      reg_b       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      data_result <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            reg_a       <= data_operandA;
            reg_b       <= (sub == ADDSUB_OP_ADD) ? data_operandB : ~data_operandB;
            carry_q     <= (sub == ADDSUB_OP_SUB);
            idx         <= '0;
            data_result <= '0;
            busy        <= 1'b1;
            state       <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          data_result[8*idx +: 8] <= rca_s;
          carry_q                 <= rca_co;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            carry_out <= rca_co;
            // Operand sign bits are compared after B has been conditionally inverted
            overflow  <= (reg_a[W-1] == reg_b[W-1]) && (rca_s[7] != reg_a[W-1]);
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_addsub.sv
// Self-checking bench for byte_serial_addsub (NBYTES = 4): directed vector
// table, multi-cycle corner sequences and randomized operations against an
// arithmetic reference model.
module tb_byte_serial_addsub;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        busy;
  logic        done;
  logic [31:0] data_result;
  logic        carry_out;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  byte_serial_addsub #(.NBYTES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .sub           (sub),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .busy          (busy),
    .done          (done),
    .data_result   (data_result),
    .carry_out     (carry_out),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic        co;
    logic        ov;
    logic        b2b;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference: plain W-bit arithmetic from the add/subtract rules
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] r, output logic co, output logic ov);
    logic [32:0] t;
    if (!s) begin
      t  = {1'b0, a} + {1'b0, b};
      r  = t[31:0];
      co = t[32];
      ov = (a[31] == b[31]) && (r[31] != a[31]);
    end else begin
      r  = a - b;
      co = (a >= b);
      ov = (a[31] != b[31]) && (r[31] != a[31]);
    end
  endtask

  // Present a request and let the accepting edge pass; caller is 1 time unit past an edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    start         = 1'b1;
    sub           = s;
    data_operandA = a;
    data_operandB = b;
    tick();
    start         = 1'b0;
    sub           = $urandom_range(0, 1);
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Wait for done; returns cycles after the accepting edge and cycles with busy high
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cycles++;
      tick();
      cycles++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done within 20", cycles);
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] r, input logic co, input logic ov);
    chk({tag, "_result"}, data_result, r);
    chk({tag, "_carry"}, {31'd0, carry_out}, {31'd0, co});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ov});
  endtask

  initial begin
    int cyc, bcyc, dones;
    logic [31:0] mr;
    logic mco, mov;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1};

    reset         = 1'b1;
    start         = 1'b0;
    sub           = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    check_result("reset", 32'd0, 1'b0, 1'b0);

    // Directed table; the last entry starts in the DONE cycle of the previous one
    for (int i = 0; i < 5; i++) begin
      if (!vecs[i].b2b) tick();
      start_op(vecs[i].a, vecs[i].b, vecs[i].s);
      chk($sformatf("v%0d_busy_after_start", i), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_result_cleared", i), data_result, 32'd0);
      wait_done(cyc, bcyc);
      chk($sformatf("v%0d_latency", i), cyc, 32'd4);
      chk($sformatf("v%0d_busy_cycles", i), bcyc, 32'd4);
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      check_result($sformatf("v%0d", i), vecs[i].r, vecs[i].co, vecs[i].ov);
    end

    // done is a single-cycle pulse and results hold through IDLE
    tick();
    chk("done_pulse_width", {31'd0, done}, 32'd0);
    tick();
    tick();
    check_result("hold_idle", 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Start during RUN is ignored
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    tick();
    start         = 1'b1;
    sub           = 1'b1;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0BAD_F00D;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      tick();
    end
    chk("busy_start_dones", dones, 32'd1);
    check_result("busy_start", 32'h2345_6789, 1'b0, 1'b0);

    // Reset on the second RUN cycle aborts the operation
    tick();
    start_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    wait_done(cyc, bcyc);
    tick();
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    check_result("midreset", 32'd0, 1'b0, 1'b0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      tick();
    end
    chk("midreset_no_done", dones, 32'd0);
    start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    wait_done(cyc, bcyc);
    chk("after_reset_latency", cyc, 32'd4);
    check_result("after_reset", 32'h0001_0000, 1'b0, 1'b0);

    // Randomized operations, mixing idle gaps and back-to-back starts
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom;
      b = $urandom;
      s = $urandom_range(0, 1);
      if (i % 4 == 1) b = ~a + 32'(s);
      if (i % 4 == 2) a = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int g = $urandom_range(1, 3); g > 0; g--) tick();
      end
      model(a, b, s, mr, mco, mov);
      start_op(a, b, s);
      wait_done(cyc, bcyc);
      chk($sformatf("rnd%0d_latency", i), cyc, 32'd4);
      check_result($sformatf("rnd%0d", i), mr, mco, mov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1);
  end

endmodule
